// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Optional feature macro: BOOTH_MUL_SEQ_EARLY_EXIT_EN (early termination).
package booth_mul_pkg;

    localparam int unsigned BOOTH_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Partial-product selection for one radix-4 Booth group
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        N2M  = 3'd3,
        NM   = 3'd4
    } booth_op_e;

    // Map {q[2k+1], q[2k], q[2k-1]} to the partial-product operation
    function automatic booth_op_e booth_decode(input logic [2:0] grp);
        booth_op_e op;
        case (grp)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = N2M;
            3'b101, 3'b110: op = NM;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product generator: (group, M) -> signed W+2-bit product.
// Macro BOOTH_MUL_SEQ_EARLY_EXIT_EN does not affect this block.
module booth_pp_sel
    import booth_mul_pkg::*;
#(
    parameter int unsigned W = BOOTH_W_DEFAULT
) (
    input  logic [2:0]   i_group,
    input  logic [W-1:0] i_m,
    output logic [W+1:0] o_pp_c
);

    logic [W+1:0] w_m1;
    logic [W+1:0] w_m2;

    // Two guard bits keep -2M representable for the most negative M
    assign w_m1 = {{2{i_m[W-1]}}, i_m};
    assign w_m2 = {i_m[W-1], i_m, 1'b0};

    // Select the partial product for this group
    always_comb begin
        o_pp_c = '0;
        case (booth_decode(i_group))
            PM:      o_pp_c = w_m1;
            P2M:     o_pp_c = w_m2;
            N2M:     o_pp_c = -w_m2;
            NM:      o_pp_c = -w_m1;
            default: o_pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth group per RUN cycle,
// valid/ready handshake on both sides.
// Macro BOOTH_MUL_SEQ_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits produce only zero groups.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int unsigned W = BOOTH_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   M,
    input  logic [W-1:0]   Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] acc,
    output logic           busy
);

    localparam int unsigned KW    = $clog2(W/2);
    localparam int unsigned AW    = 2*W;
    localparam int unsigned K_MAX = W/2 - 1;

    state_e          r_state,     nx_state;
    logic [W-1:0]    r_m,         nx_m;
    logic [W-1:0]    r_q,         nx_q;
    logic [AW-1:0]   r_acc,       nx_acc;
    logic [KW-1:0]   r_k,         nx_k;
    logic            r_in_ready,  nx_in_ready;
    logic            r_out_valid, nx_out_valid;
    logic            r_busy,      nx_busy;

    logic [W:0]      w_qx;
    logic [2:0]      w_group;
    logic [W+1:0]    w_pp;
    logic [AW-1:0]   w_pp_ext;
    logic [AW-1:0]   w_pp_sh;
    logic            w_last;
    logic            w_exit;

    // Current Booth group, with the implicit Q[-1] = 0 appended below bit 0
    assign w_qx    = {r_q, 1'b0};
    assign w_group = w_qx[{r_k, 1'b0} +: 3];
    assign w_last  = (r_k == KW'(K_MAX));

    booth_pp_sel #(.W(W)) u_pp_sel (
        .i_group (w_group),
        .i_m     (r_m),
        .o_pp_c  (w_pp)
    );

    // Sign-extend the partial product to the accumulator width and weight it by 4^k
    assign w_pp_ext = {{(W-2){w_pp[W+1]}}, w_pp};
    assign w_pp_sh  = w_pp_ext << {r_k, 1'b0};

`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
    logic [W-1:0] w_hi;
    // Q[W-1:2k+1] all equal means every remaining group decodes to zero
    assign w_hi   = $signed(r_q) >>> ({r_k, 1'b0} + 1'b1);
    assign w_exit = (w_hi == '0) || (w_hi == '1);
`else
    assign w_exit = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        nx_state     = r_state;
        nx_m         = r_m;
        nx_q         = r_q;
        nx_acc       = r_acc;
        nx_k         = r_k;
        nx_in_ready  = r_in_ready;
        nx_out_valid = r_out_valid;
        nx_busy      = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    nx_m        = M;
                    nx_q        = Q;
                    nx_acc      = '0;
                    nx_k        = '0;
                    nx_state    = ST_RUN;
                    nx_in_ready = 1'b0;
                    nx_busy     = 1'b1;
                end
            end
            ST_RUN: begin
                nx_acc = r_acc + w_pp_sh;
                if (w_last || w_exit) begin
                    nx_state     = ST_DONE;
                    nx_out_valid = 1'b1;
                end else begin
                    nx_k = r_k + KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    nx_state     = ST_IDLE;
                    nx_out_valid = 1'b0;
                    nx_in_ready  = 1'b1;
                    nx_busy      = 1'b0;
                end
            end
            default: begin
                nx_state     = ST_IDLE;
                nx_out_valid = 1'b0;
                nx_in_ready  = 1'b1;
                nx_busy      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_m         <= '0;
            r_q         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= nx_state;
            r_m         <= nx_m;
            r_q         <= nx_q;
            r_acc       <= nx_acc;
            r_k         <= nx_k;
            r_in_ready  <= nx_in_ready;
            r_out_valid <= nx_out_valid;
            r_busy      <= nx_busy;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign acc       = r_acc;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and streaming checks for booth_mul_seq (W = 12).
// Honors BOOTH_MUL_SEQ_EARLY_EXIT_EN for expected latencies.
module tb_booth_mul_seq;

    localparam int W = 12;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   M;
    logic signed [W-1:0]   Q;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W-1:0] acc;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    booth_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0]   m;
        logic signed [W-1:0]   q;
        logic signed [2*W-1:0] p;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected RUN-cycle count for a given multiplier
    function automatic int exp_lat(input logic [W-1:0] q);
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
        logic [W-1:0] s;
        for (int k = 0; k < W/2; k++) begin
            s = $signed(q) >>> (2*k + 1);
            if (s == '0 || s == '1) return k + 1;
        end
        return W/2;
`else
        return (q == q) ? W/2 : W/2;
`endif
    endfunction

    // One complete operation; returns product and cycles from transfer to out_valid
    task automatic run_op(input logic signed [W-1:0] m, input logic signed [W-1:0] q,
                          output logic signed [2*W-1:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        M = m; Q = q; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = acc;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_done", longint'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic signed [2*W-1:0] res;
        logic signed [2*W-1:0] snap;
        logic signed [2*W-1:0] q_exp[$];
        logic signed [2*W-1:0] e;
        longint pm, pq;
        int lat, guard, sent, recvd, cyc, sel;

        vecs[0]  = '{12'sd5,     12'sd7,     24'sd35};
        vecs[1]  = '{-12'sd2048, -12'sd2048, 24'sh400000};
        vecs[2]  = '{-12'sd1,    12'sd1,     24'shFFFFFF};
        vecs[3]  = '{12'sd2047,  -12'sd2048, -24'sd4192256};
        vecs[4]  = '{12'sd3,     12'sd4,     24'sd12};
        vecs[5]  = '{12'sd0,     -12'sd777,  24'sd0};
        vecs[6]  = '{-12'sd7,    12'sd13,    -24'sd91};
        vecs[7]  = '{12'sd1234,  -12'sd567,  -24'sd699678};
        vecs[8]  = '{12'sd2047,  12'sd2047,  24'sd4190209};
        vecs[9]  = '{-12'sd2048, 12'sd2047,  -24'sd4192256};
        vecs[10] = '{12'sd100,   -12'sd100,  -24'sd10000};
        vecs[11] = '{12'sd9,     12'sd1,     24'sd9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; M = '0; Q = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_acc", acc, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].m, vecs[i].q, res, lat);
            chk($sformatf("vec%0d_product", i), res, vecs[i].p);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].q));
        end

        // Multiplier-dependent latency corners
        run_op(12'sd9, 12'sd1, res, lat);
        chk("q1_product", res, 9);
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
        chk("q1_latency", lat, 1);
`else
        chk("q1_latency", lat, 6);
`endif
        run_op(12'sd9, -12'sd1, res, lat);
        chk("qm1_product", res, -9);
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
        chk("qm1_latency", lat, 1);
`else
        chk("qm1_latency", lat, 6);
`endif
        run_op(12'sd3, 12'sh400, res, lat);
        chk("q400_product", res, 3072);
        chk("q400_latency", lat, 6);

        // Hold in DONE while consumer stalls; new operands must be ignored
        @(negedge clk);
        M = 12'sd5; Q = 12'sd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("run_busy", longint'(busy), 1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("hold_first", acc, 35);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; M = 12'sd77; Q = 12'sd3;
            @(posedge clk); #1;
            chk("hold_acc", acc, 35);
            chk("hold_flags", longint'({out_valid, in_ready, busy}), 5);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", longint'(in_ready), 1);
        chk("release_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("release_idle_busy", longint'(busy), 0);

        // Reset during RUN cycle 3
        @(negedge clk);
        M = 12'sd100; Q = 12'sd55; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_in_ready", longint'(in_ready), 1);
        chk("midrun_rst_out_valid", longint'(out_valid), 0);
        chk("midrun_rst_busy", longint'(busy), 0);
        chk("midrun_rst_acc", acc, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(12'sd3, 12'sd4, res, lat);
        chk("after_rst_product", res, 12);

        // Random stream with random handshakes on both sides
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 7);
            M = (sel == 0) ? -12'sd2048 : (sel == 1) ? 12'sd2047 : W'($urandom);
            sel = $urandom_range(0, 7);
            Q = (sel == 0) ? -12'sd2048 : (sel == 1) ? -12'sd1 : W'($urandom);
            if (in_valid && in_ready) begin
                pm = M;
                pq = Q;
                q_exp.push_back((2*W)'(pm * pq));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_extra: got=%0d expected=no result", acc);
                end else begin
                    e = q_exp.pop_front();
                    chk("stream_product", acc, e);
                end
                recvd++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_sent", sent, 1000);
        chk("stream_received", recvd, 1000);
        chk("stream_leftover", q_exp.size(), 0);
        snap = acc;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 Parameter: W, 12, operand width in bits; even, >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand pair M/Q presented.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: M  input  W  multiplicand, signed two's complement.
REQ-007 Port: Q  input  W  multiplier, signed two's complement.
REQ-008 Port: out_valid  output  1  acc holds a finished product.
REQ-009 Port: out_ready  input  1  consumer takes acc.
REQ-010 Port: acc  output  2W  signed product.
REQ-011 Port: busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL be an iterative radix-4 Booth multiplier that reuses one partial-product generator, processing one Booth group per cycle.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL equal (state==IDLE); transfer occurs on in_valid && in_ready at a rising edge.
REQ-015 On transfer, the block SHALL latch M and Q, clear the accumulator and group counter k, and enter RUN.
REQ-016 In RUN cycle k (k = 0..W/2-1), the group SHALL be {Q[2k+1], Q[2k], Q[2k-1]}, with Q[-1] = 0.
REQ-017 Group encoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-018 Each partial product SHALL be formed W+2 bits wide, so that -2M with M = -2^(W-1) does not overflow.
REQ-019 Each partial product SHALL be sign-extended to 2W, shifted left by 2k, and added to the accumulator, modulo 2^(2W).
REQ-020 After group W/2-1 (or an early exit per REQ-030), the FSM SHALL enter DONE with out_valid = 1.
REQ-021 Latency: a transfer at edge T SHALL give out_valid high after edge T+W/2 (T+6 for W=12).
REQ-022 acc SHALL equal $signed(M)*$signed(Q) exactly for all inputs.
REQ-023 In DONE, acc and out_valid SHALL hold stable until out_ready = 1.
REQ-024 On out_valid && out_ready, the FSM SHALL return to IDLE, so in_ready is high in the next cycle.
REQ-025 No operand SHALL be accepted while in RUN or DONE; in_valid is ignored in those states.
REQ-026 acc SHALL be don't-care when out_valid = 0, and SHALL NOT change outside RUN.

Reset
REQ-027 On rst at a rising edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, busy=0, acc=0, and k=0, regardless of current state.
REQ-028 Reset mid-RUN or mid-DONE SHALL discard the operation with no output; the first cycle after reset is IDLE.

Configuration
REQ-029 Macro BOOTH_MUL_SEQ_EARLY_EXIT_EN SHALL control early termination.
REQ-030 With the macro defined: after processing group k, if bits Q[W-1:2k+1] are all equal, the FSM SHALL go to DONE at once. All remaining groups are then zero, so latency is 1..W/2 cycles and acc is unchanged.
REQ-031 Without the macro, every operation SHALL take exactly W/2 RUN cycles.

Structure
REQ-032 Package booth_mul_pkg SHALL hold the FSM state enum, the Booth group encoding constants (ZERO, PM, P2M, N2M, NM), and the default W.
REQ-033 One combinational sub-module, booth_pp_sel, SHALL map (group[2:0], M) to a (W+2)-bit signed partial product; booth_mul_seq SHALL instantiate it once.
REQ-034 The group counter SHALL be $clog2(W/2) bits wide and SHALL NOT wrap past W/2-1.

Verification
REQ-035 M=5, Q=7, out_ready=1 -> acc=35, out_valid exactly 6 cycles after transfer (macro off).
REQ-036 M=-2048, Q=-2048 -> acc=24'h400000; M=-1, Q=1 -> acc=24'hFFFFFF; M=2047, Q=-2048 -> acc=-4192256.
REQ-037 out_ready held 0 for 10 cycles in DONE -> acc and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst asserted in RUN cycle 3 -> next cycle IDLE, out_valid=0, acc=0; a following 3*4 operation yields 12.
REQ-039 Macro on: Q=1, M=9 -> acc=9 after 1 RUN cycle; Q=-1 -> 1 cycle; Q=12'h400 -> 6 cycles; results match macro-off results.
REQ-040 Back-to-back stream of 1000 random pairs with random in_valid/out_ready -> every acc matches the signed reference product, in order, none lost or duplicated.
